// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Opcode constants, ALUOp codes driven into ALU_Control, PCSource mux codes
// and the main-control state encoding (also exported on the State debug port).
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_RTYPE = 2'd2,
      ALU_OR    = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      PCS_ALU    = 2'd0,
      PCS_ALUOUT = 2'd1,
      PCS_JUMP   = 2'd2,
      PCS_RS     = 2'd3
   } pc_src_e;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ORI_EXEC  = 4'd10,
      S_ORI_WB    = 4'd11,
      S_TRAP      = 4'd12
   } state_e;

   // States that wait on the memory handshake and are guarded by the timer.
   function automatic logic is_mem_wait(state_e s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait timer for the main control FSM.
// Counts cycles spent waiting for Mem_Ready and flags a timeout once the count
// reaches MEM_TIMEOUT while ready is still low. Saturates instead of wrapping.
// Ports: clk, rst (sync, active-high), clear_i (state change), enable_i (in a
// memory-wait state), ready_i (Mem_Ready), timeout_o (combinational).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMR_W       = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   input  logic ready_i,
   output logic timeout_o
);

   localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);
   localparam logic [TMR_W-1:0] SAT   = '1;

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && !ready_i && (cnt_q != SAT))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Ready in the limit cycle completes the access, so ready masks the timeout.
   assign timeout_o = enable_i && !ready_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback, stalls on the single-port
// memory handshake, and traps on illegal opcodes or memory timeout.
// Ports: clk, rst (sync, active-high); Opcode, JumpRegister, Mem_Ready in;
// datapath controls, PCSource, ALUSrcB, ALUOp, sticky Illegal_Op/Bus_Error,
// and State (debug) out.
//
// state     | meaning
// FETCH     | read instruction, PC+4; waits for Mem_Ready
// DECODE    | branch target into ALUOut, dispatch on Opcode
// MEM_ADDR  | base + offset for lw/sw
// MEM_READ  | data read; waits for Mem_Ready
// MEM_WB    | load data to rt
// MEM_WRITE | data write; waits for Mem_Ready
// EXECUTE   | R-type ALU op, or jr when JumpRegister
// R_WB      | ALUOut to rd
// BRANCH    | beq compare, conditional PC write
// JUMP      | PC <- jump target
// ORI_EXEC  | rs | zero-ext imm
// ORI_WB    | ALUOut to rt
// TRAP      | all controls off until reset
module multicycle_main_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMR_W       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Opcode,
   input  logic       JumpRegister,
   input  logic       Mem_Ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] PCSource,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       Illegal_Op,
   output logic       Bus_Error,
   output logic [3:0] State
);

   state_e state_q, state_d;
   logic   is_sw_q, is_sw_d;
   logic   illegal_q, illegal_d;
   logic   bus_err_q, bus_err_d;
   logic   timeout;
   logic   pc_wr, pc_wr_cond, mem_wr, ir_wr, reg_wr;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TMR_W       (TMR_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_d != state_q),
      .enable_i  (is_mem_wait(state_q)),
      .ready_i   (Mem_Ready),
      .timeout_o (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         is_sw_q   <= 1'b0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_sw_q   <= is_sw_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      is_sw_d   = is_sw_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      unique case (state_q)
         S_FETCH: begin
            if (Mem_Ready)    state_d = S_DECODE;
            else if (timeout) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end
         end
         S_DECODE: begin
            // Only place Opcode is looked at; lw/sw choice is carried forward.
            is_sw_d = (Opcode == OP_SW);
            case (Opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ORI:       state_d = S_ORI_EXEC;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR:  state_d = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ, S_MEM_WRITE: begin
            if (Mem_Ready)    state_d = (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
            else if (timeout) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end
         end
         S_EXECUTE:   state_d = JumpRegister ? S_FETCH : S_R_WB;
         S_ORI_EXEC:  state_d = S_ORI_WB;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_wr       = 1'b0;
      pc_wr_cond  = 1'b0;
      mem_wr      = 1'b0;
      ir_wr       = 1'b0;
      reg_wr      = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      PCSource    = PCS_ALU;
      ALUSrcB     = 2'd0;
      ALUOp       = ALU_ADD;
      unique case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            ir_wr   = Mem_Ready;
            pc_wr   = Mem_Ready;
         end
         S_DECODE:    ALUSrcB = 2'd3;
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
         end
         S_MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WB: begin
            reg_wr   = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_wr = 1'b1;
            IorD   = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_RTYPE;
            if (JumpRegister) begin
               pc_wr    = 1'b1;
               PCSource = PCS_RS;
            end
         end
         S_R_WB: begin
            reg_wr = 1'b1;
            RegDst = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUOp      = ALU_SUB;
            pc_wr_cond = 1'b1;
            PCSource   = PCS_ALUOUT;
         end
         S_JUMP: begin
            pc_wr    = 1'b1;
            PCSource = PCS_JUMP;
         end
         S_ORI_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            ALUOp   = ALU_OR;
         end
         S_ORI_WB:    reg_wr = 1'b1;
         default: ;
      endcase
   end

   // Write enables are suppressed while reset is held so nothing is corrupted.
   assign PCWrite     = pc_wr      & ~rst;
   assign PCWriteCond = pc_wr_cond & ~rst;
   assign MemWrite    = mem_wr     & ~rst;
   assign IRWrite     = ir_wr      & ~rst;
   assign RegWrite    = reg_wr     & ~rst;

   assign Illegal_Op  = illegal_q;
   assign Bus_Error   = bus_err_q;
   assign State       = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] Opcode;
   logic       JumpRegister;
   logic       Mem_Ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0] PCSource, ALUSrcB, ALUOp;
   logic       Illegal_Op, Bus_Error;
   logic [3:0] State;
   logic [5:0] funct;

   always #5 clk = ~clk;

   // Stand-in for ALU_Control: jr is funct 8 under ALUOp 2.
   assign JumpRegister = (ALUOp == 2'd2) && (funct == 6'd8);

   multicycle_main_control dut (
      .clk(clk), .rst(rst), .Opcode(Opcode), .JumpRegister(JumpRegister),
      .Mem_Ready(Mem_Ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .Illegal_Op(Illegal_Op), .Bus_Error(Bus_Error),
      .State(State)
   );

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
   //  RegDst,ALUSrcA,PCSource,ALUSrcB,ALUOp,Illegal_Op,Bus_Error,State}
   logic [21:0] dut_vec;
   assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB,
                     ALUOp, Illegal_Op, Bus_Error, State};

   logic [21:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          vec_no   = 0;

   // Hand table of controls per state.
   function automatic logic [21:0] expect_vec(input int st, input logic rdy,
                                              input logic jr, input logic r,
                                              input logic ill, input logic bus);
      logic pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa;
      logic [1:0] pcs, sb, op;
      {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa} = '0;
      pcs = 2'd0; sb = 2'd0; op = 2'd0;
      case (st)
         0:  begin mrd = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
         1:  sb = 2'd3;
         2:  begin sa = 1; sb = 2'd2; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin sa = 1; op = 2'd2; if (jr) begin pcw = 1; pcs = 2'd3; end end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; op = 2'd1; pcc = 1; pcs = 2'd1; end
         9:  begin pcw = 1; pcs = 2'd2; end
         10: begin sa = 1; sb = 2'd2; op = 2'd3; end
         11: rw = 1;
         default: ;
      endcase
      if (r) begin pcw = 0; pcc = 0; mwr = 0; irw = 0; rw = 0; end
      return {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa, pcs, sb, op,
              ill, bus, 4'(st)};
   endfunction

   // One cycle of stimulus: drive inputs, queue the expected output vector.
   task automatic cyc(input int st, input logic rdy, input logic [5:0] op,
                      input logic jr, input logic r, input logic ill, input logic bus);
      rst       = r;
      Mem_Ready = rdy;
      Opcode    = op;
      funct     = jr ? 6'd8 : 6'd32;
      exp_q.push_back(expect_vec(st, rdy, jr, r, ill, bus));
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [21:0] e;
         e = exp_q.pop_front();
         n_checks++;
         vec_no++;
         if (dut_vec === e) n_pass++;
         else $display("FAIL vec%0d: got %h (state %0d) required %h (state %0d)",
                       vec_no, dut_vec, dut_vec[3:0], e, e[3:0]);
      end
   end

   initial begin
      rst = 1'b1; Mem_Ready = 1'b0; Opcode = 6'd0; funct = 6'd32;
      @(posedge clk); #1;
      // reset held in FETCH with ready high: write enables stay off
      cyc(0, 1, 0, 0, 1, 0, 0);
      // lw: 0,1,2,3,4; opcode wiggles after DECODE are ignored
      cyc(0, 1, 35, 0, 0, 0, 0);
      cyc(1, 1, 35, 0, 0, 0, 0);
      cyc(2, 1, 43, 0, 0, 0, 0);
      cyc(3, 1, 43, 0, 0, 0, 0);
      cyc(4, 1, 0,  0, 0, 0, 0);
      // R-type add
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(6, 1, 0, 0, 0, 0, 0);
      cyc(7, 1, 0, 0, 0, 0, 0);
      // jr
      cyc(0, 1, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 0, 0);
      cyc(6, 1, 0, 1, 0, 0, 0);
      // FETCH stall 3 cycles then ready, then beq
      cyc(0, 0, 4, 0, 0, 0, 0);
      cyc(0, 0, 4, 0, 0, 0, 0);
      cyc(0, 0, 4, 0, 0, 0, 0);
      cyc(0, 1, 4, 0, 0, 0, 0);
      cyc(1, 1, 4, 0, 0, 0, 0);
      cyc(8, 1, 4, 0, 0, 0, 0);
      // j
      cyc(0, 1, 2, 0, 0, 0, 0);
      cyc(1, 1, 2, 0, 0, 0, 0);
      cyc(9, 1, 2, 0, 0, 0, 0);
      // ori
      cyc(0, 1, 13, 0, 0, 0, 0);
      cyc(1, 1, 13, 0, 0, 0, 0);
      cyc(10, 1, 13, 0, 0, 0, 0);
      cyc(11, 1, 13, 0, 0, 0, 0);
      // sw, ready arrives in the cycle the wait count reaches 15: no error
      cyc(0, 1, 43, 0, 0, 0, 0);
      cyc(1, 1, 43, 0, 0, 0, 0);
      cyc(2, 1, 43, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) cyc(5, 0, 43, 0, 0, 0, 0);
      cyc(5, 1, 43, 0, 0, 0, 0);
      // sw, ready stuck low: count 0..15 in MEM_WRITE, then TRAP
      cyc(0, 1, 43, 0, 0, 0, 0);
      cyc(1, 1, 43, 0, 0, 0, 0);
      cyc(2, 1, 43, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(5, 0, 43, 0, 0, 0, 0);
      cyc(12, 0, 43, 0, 0, 0, 1);
      cyc(12, 1, 0,  0, 0, 0, 1);
      cyc(12, 1, 0,  0, 1, 0, 1);
      // illegal opcode 63, sticky for 20 cycles
      cyc(0, 1, 63, 0, 0, 0, 0);
      cyc(1, 1, 63, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(12, i[0], (i[1] ? 6'd35 : 6'd0), 0, 0, 1, 0);
      cyc(12, 1, 0, 0, 1, 1, 0);
      // reset mid MEM_WRITE, then beq
      cyc(0, 1, 43, 0, 0, 0, 0);
      cyc(1, 1, 43, 0, 0, 0, 0);
      cyc(2, 1, 43, 0, 0, 0, 0);
      cyc(5, 0, 43, 0, 0, 0, 0);
      cyc(5, 0, 43, 0, 1, 0, 0);
      cyc(0, 1, 4, 0, 0, 0, 0);
      cyc(1, 1, 4, 0, 0, 0, 0);
      cyc(8, 1, 4, 0, 0, 0, 0);
      cyc(0, 0, 4, 0, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d vectors left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
